// File: rtl/core_types_pkg.sv
// Core-wide physical register and free list sizing shared by rename/commit blocks.
package core_types_pkg;

    localparam int PR_COUNT                    = 128;
    localparam int LOG_PR_COUNT                = $clog2(PR_COUNT);
    localparam int FREE_LIST_BANK_COUNT        = 4;
    localparam int LOG_FREE_LIST_BANK_COUNT    = $clog2(FREE_LIST_BANK_COUNT);
    localparam int FREE_LIST_SHIFT_REG_ENTRIES = 12;

endpackage

// File: rtl/pe_lsb.sv
// Priority encoder: reports the lowest set request bit and whether any bit is set.
module pe_lsb #(
    parameter int WIDTH = 12,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             found_o
);

    always_comb begin
        idx_o   = '0;
        found_o = |req_i;
        // Scan downward so the lowest set index is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                idx_o = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/free_list_dealloc_buffer.sv
// Age-ordered compacting buffer between ROB commit and the banked free list.
module free_list_dealloc_buffer
    import core_types_pkg::*;
#(
    parameter int ENTRIES      = FREE_LIST_SHIFT_REG_ENTRIES,
    parameter int DEALLOC_WAYS = 4,
    parameter int BANK_COUNT   = FREE_LIST_BANK_COUNT
) (
    input  logic                                     CLK,
    input  logic                                     RST,
    input  logic [DEALLOC_WAYS-1:0]                  dealloc_valid_by_way,
    input  logic [DEALLOC_WAYS-1:0][LOG_PR_COUNT-1:0] dealloc_pr_by_way,
    output logic                                     dealloc_ready,
    output logic [BANK_COUNT-1:0]                    enq_valid_by_bank,
    output logic [BANK_COUNT-1:0][LOG_PR_COUNT-1:0]  enq_pr_by_bank,
    input  logic [BANK_COUNT-1:0]                    enq_ready_by_bank,
    output logic                                     buffer_empty
);

    localparam int IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam int CNT_W = $clog2(ENTRIES + 1);
    localparam logic [CNT_W-1:0] ENTRIES_C   = CNT_W'(ENTRIES);
    localparam logic [CNT_W-1:0] READY_MAX_C = CNT_W'(ENTRIES - DEALLOC_WAYS);

    typedef struct packed {
        logic                    valid;
        logic [LOG_PR_COUNT-1:0] pr;
    } entry_t;

    entry_t [ENTRIES-1:0]             ent_q;
    entry_t [ENTRIES-1:0]             ent_d;
    logic   [CNT_W-1:0]               occ;
    logic   [CNT_W-1:0]               wr;
    logic   [ENTRIES-1:0]             remove;
    logic   [DEALLOC_WAYS-1:0]        accept;
    logic   [BANK_COUNT-1:0]          sel_found;
    logic   [BANK_COUNT-1:0][IDX_W-1:0] sel_idx;

    always_comb begin
        occ = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            occ = occ + CNT_W'(ent_q[i].valid);
        end
    end

    assign dealloc_ready = (occ <= READY_MAX_C);
    assign buffer_empty  = (occ == '0);
    assign accept        = dealloc_valid_by_way & {DEALLOC_WAYS{dealloc_ready}};

    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        logic [ENTRIES-1:0] match;
        logic [IDX_W-1:0]   idx;
        logic               found;

        always_comb begin
            for (int i = 0; i < ENTRIES; i++) begin
                match[i] = ent_q[i].valid &&
                           (ent_q[i].pr[LOG_FREE_LIST_BANK_COUNT-1:0] == LOG_FREE_LIST_BANK_COUNT'(b));
            end
        end

        pe_lsb #(.WIDTH(ENTRIES), .IDX_W(IDX_W)) u_pe (
            .req_i   (match),
            .idx_o   (idx),
            .found_o (found)
        );

        assign sel_found[b]         = found;
        assign sel_idx[b]           = idx;
        assign enq_valid_by_bank[b] = found;
        assign enq_pr_by_bank[b]    = found ? ent_q[idx].pr : '0;
    end

    always_comb begin
        remove = '0;
        for (int b = 0; b < BANK_COUNT; b++) begin
            if (sel_found[b] && enq_ready_by_bank[b]) begin
                remove[sel_idx[b]] = 1'b1;
            end
        end
    end

    // Survivors keep their relative order, then accepted ways fill in behind them.
    always_comb begin
        ent_d = '0;
        wr    = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (ent_q[i].valid && !remove[i]) begin
                ent_d[wr[IDX_W-1:0]] = ent_q[i];
                wr = wr + 1'b1;
            end
        end
        for (int w = 0; w < DEALLOC_WAYS; w++) begin
            if (accept[w] && (wr < ENTRIES_C)) begin
                ent_d[wr[IDX_W-1:0]] = '{valid: 1'b1, pr: dealloc_pr_by_way[w]};
                wr = wr + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < ENTRIES; i++) begin
            ent_q[i].pr <= ent_d[i].pr;
            if (RST) begin
                ent_q[i].valid <= 1'b0;
            end else begin
                ent_q[i].valid <= ent_d[i].valid;
            end
        end
    end

endmodule

// File: tb/tb_free_list_dealloc_buffer.sv
// Directed bench with a queue-based reference model of the dealloc buffer.
module tb_free_list_dealloc_buffer;
    import core_types_pkg::*;

    localparam int ENT   = 12;
    localparam int WAYS  = 4;
    localparam int BANKS = 4;

    logic                                   clk;
    logic                                   rst;
    logic [WAYS-1:0]                        dv;
    logic [WAYS-1:0][LOG_PR_COUNT-1:0]      dp;
    logic                                   dealloc_ready;
    logic [BANKS-1:0]                       enq_valid;
    logic [BANKS-1:0][LOG_PR_COUNT-1:0]     enq_pr;
    logic [BANKS-1:0]                       er;
    logic                                   buffer_empty;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;
    int mq[$];
    int found_m, epr_m, j_m;
    bit rdy_m;

    free_list_dealloc_buffer #(.ENTRIES(ENT), .DEALLOC_WAYS(WAYS), .BANK_COUNT(BANKS)) dut (
        .CLK                  (clk),
        .RST                  (rst),
        .dealloc_valid_by_way (dv),
        .dealloc_pr_by_way    (dp),
        .dealloc_ready        (dealloc_ready),
        .enq_valid_by_bank    (enq_valid),
        .enq_pr_by_bank       (enq_pr),
        .enq_ready_by_bank    (er),
        .buffer_empty         (buffer_empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Reference model: plain queue in age order; bank is pr mod BANKS.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
        end else begin
            rdy_m = (mq.size() <= ENT - WAYS);
            for (int b = 0; b < BANKS; b++) begin
                if (er[b]) begin
                    j_m = -1;
                    for (int j = 0; j < mq.size(); j++)
                        if (j_m < 0 && (mq[j] % BANKS) == b) j_m = j;
                    if (j_m >= 0) mq.delete(j_m);
                end
            end
            if (rdy_m)
                for (int w = 0; w < WAYS; w++)
                    if (dv[w]) mq.push_back(int'(dp[w]));
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("dealloc_ready", 32'(dealloc_ready), 32'(mq.size() <= ENT - WAYS));
            chk("buffer_empty", 32'(buffer_empty), 32'(mq.size() == 0));
            for (int b = 0; b < BANKS; b++) begin
                found_m = 0;
                epr_m   = 0;
                for (int j = 0; j < mq.size(); j++) begin
                    if (found_m == 0 && (mq[j] % BANKS) == b) begin
                        found_m = 1;
                        epr_m   = mq[j];
                    end
                end
                chk($sformatf("enq_valid[%0d]", b), 32'(enq_valid[b]), 32'(found_m));
                if (found_m != 0) chk($sformatf("enq_pr[%0d]", b), 32'(enq_pr[b]), 32'(epr_m));
            end
        end
    end

    task automatic drive(input logic [3:0] v, input int p0, input int p1, input int p2,
                         input int p3, input logic [3:0] rdy);
        dv    = v;
        dp[0] = LOG_PR_COUNT'(p0);
        dp[1] = LOG_PR_COUNT'(p1);
        dp[2] = LOG_PR_COUNT'(p2);
        dp[3] = LOG_PR_COUNT'(p3);
        er    = rdy;
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        dv  = '0;
        dp  = '0;
        er  = '0;
        @(negedge clk);
        @(negedge clk);
        chk_en = 1;
        chk("reset ready", 32'(dealloc_ready), 1);
        chk("reset enq_valid", 32'(enq_valid), 0);
        chk("reset empty", 32'(buffer_empty), 1);
        rst = 1'b0;

        // Four ways into four distinct banks.
        drive(4'b1111, 4, 5, 6, 7, 4'b0000);
        chk("r33 enq_valid", 32'(enq_valid), 32'hF);
        chk("r33 pr0", 32'(enq_pr[0]), 4);
        chk("r33 pr1", 32'(enq_pr[1]), 5);
        chk("r33 pr2", 32'(enq_pr[2]), 6);
        chk("r33 pr3", 32'(enq_pr[3]), 7);
        chk("r33 empty", 32'(buffer_empty), 0);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("r33 drained", 32'(buffer_empty), 1);

        // Three PRs share bank 0 and drain one per cycle in order.
        drive(4'b1111, 8, 12, 16, 1, 4'b1111);
        chk("r34 c1 valid", 32'(enq_valid), 32'h3);
        chk("r34 c1 b0", 32'(enq_pr[0]), 8);
        chk("r34 c1 b1", 32'(enq_pr[1]), 1);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("r34 c2 b0", 32'(enq_pr[0]), 12);
        chk("r34 c2 valid", 32'(enq_valid), 32'h1);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("r34 c3 b0", 32'(enq_pr[0]), 16);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("r34 empty", 32'(buffer_empty), 1);

        // Fill to capacity, overflow attempt, then one drain cycle.
        drive(4'b1111, 0, 1, 2, 3, 4'b0000);
        drive(4'b1111, 4, 5, 6, 7, 4'b0000);
        drive(4'b1111, 8, 9, 10, 11, 4'b0000);
        chk("r35 full occ", mq.size(), 12);
        chk("r35 full ready", 32'(dealloc_ready), 0);
        drive(4'b1111, 20, 21, 22, 23, 4'b0000);
        chk("r35 ignored occ", mq.size(), 12);
        chk("r35 ignored b0", 32'(enq_pr[0]), 0);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("r35 occ after drain", mq.size(), 8);
        chk("r35 ready back", 32'(dealloc_ready), 1);
        chk("r35 b0 next", 32'(enq_pr[0]), 4);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("r35 empty", 32'(buffer_empty), 1);

        // Single sparse way with a concurrent drain.
        drive(4'b0111, 1, 2, 3, 0, 4'b0000);
        chk("r36 occ3", mq.size(), 3);
        drive(4'b0100, 0, 0, 9, 0, 4'b0010);
        chk("r36 occ", mq.size(), 3);
        chk("r36 valid", 32'(enq_valid), 32'hE);
        chk("r36 b1", 32'(enq_pr[1]), 9);
        chk("r36 b2", 32'(enq_pr[2]), 2);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("r36 empty", 32'(buffer_empty), 1);

        // Bank 2 stalls while the others drain.
        drive(4'b1111, 2, 6, 0, 5, 4'b1011);
        for (int i = 0; i < 5; i++) begin
            chk("r37 b2 stable", 32'(enq_pr[2]), 2);
            drive((i == 1) ? 4'b1011 : 4'b0000, 4, 9, 0, 7, 4'b1011);
        end
        chk("r37 b2 still", 32'(enq_pr[2]), 2);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("r37 b2 next", 32'(enq_pr[2]), 6);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("r37 empty", 32'(buffer_empty), 1);

        // Duplicates pass through unchanged.
        drive(4'b1111, 5, 5, 5, 5, 4'b1111);
        for (int i = 0; i < 4; i++) drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("dup empty", 32'(buffer_empty), 1);

        // Reset mid-operation discards contents and same-cycle inputs.
        drive(4'b1111, 0, 4, 8, 12, 4'b0000);
        drive(4'b0111, 16, 20, 24, 0, 4'b0000);
        chk("r38 occ7", mq.size(), 7);
        rst = 1'b1;
        drive(4'b1111, 1, 2, 3, 5, 4'b1111);
        chk("r38 empty", 32'(buffer_empty), 1);
        chk("r38 enq_valid", 32'(enq_valid), 0);
        chk("r38 ready", 32'(dealloc_ready), 1);
        rst = 1'b0;

        // Mixed traffic checked cycle by cycle against the model.
        for (int i = 0; i < 60; i++)
            drive(4'($urandom), $urandom_range(0, 127), $urandom_range(0, 127),
                  $urandom_range(0, 127), $urandom_range(0, 127), 4'($urandom));
        for (int i = 0; i < 13; i++) drive(4'b0000, 0, 0, 0, 0, 4'b1111);
        chk("final empty", 32'(buffer_empty), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
